soc_bus_fabric: RTL and testbench
=================================

// Module: soc_bus_fabric
// PURPOSE
//  Parametrised picorv32 native-bus interconnect replacing hand-written SoC address decode.
//  Decodes the CPU request into N slave regions by address top byte and drives one-hot slave selects.
//  Slaves complete with their own s_ready or get a fabric-generated ack. Unmapped or hung accesses
//  complete with an error word. Sits between picorv32 and RAM/flash/LED/UART/video peripherals.
// PARAMETERS
//  N_SLAVES       6                 number of slave ports
//  SLAVE_BASES    {8'h00,8'h01,8'hfe,8'hff,8'hf0,8'hf1}  packed N*8; entry i (bits 8i+7:8i) = m_addr[31:24] of slave i
//  AUTOACK_MASK   6'b111100         bit i=1: fabric acks slave i itself, s_ready[i] ignored
//  TIMEOUT_CYCLES 255               ACCESS cycles before forced completion; 0 disables timeout
//  ERR_RDATA      32'hDEAD_BEEF     read data returned on decode miss or timeout
// PORTS
//  clk_cpu     in   1      fabric clock (CPU clock domain)
//  n_reset     in   1      asynchronous reset, active low
//  m_valid     in   1      CPU request valid
//  m_instr     in   1      instruction fetch flag (latched, forwarded to s_instr)
//  m_addr      in   32     CPU address
//  m_wdata     in   32     CPU write data
//  m_wstrb     in   4      CPU byte write strobes; 0 = read
//  m_ready     out  1      one-cycle completion pulse to CPU
//  m_rdata     out  32     read data, valid while m_ready=1
//  s_sel       out  N      one-hot slave select
//  s_instr     out  1      latched m_instr
//  s_addr      out  32     latched address
//  s_wdata     out  32     latched write data
//  s_wstrb     out  4      latched strobes, gated: nonzero only while s_sel!=0
//  s_ready     in   N      per-slave completion (level; sampled only for the selected slave)
//  s_rdata     in   32*N   per-slave read data; slave i = bits 32i+31:32i
//  bus_err     out  1      one-cycle pulse on decode miss or timeout
//  err_addr    out  32     address of the most recent error
//  err_count   out  8      error counter, saturates at 255
// BEHAVIOUR
//  Reset: state IDLE; m_ready=0, m_rdata=0, s_sel=0, s_instr=0, s_addr=0, s_wdata=0, s_wstrb=0,
//   bus_err=0, err_addr=0, err_count=0. Async reset mid-transaction aborts it; no completion issued.
//  FSM IDLE/ACCESS/RESP, all outputs registered.
//  IDLE: m_valid=1 -> latch addr/wdata/wstrb/instr; decode m_addr[31:24] against SLAVE_BASES,
//   lowest index wins on duplicates. Hit i -> ACCESS, s_sel[i]=1 next cycle, timeout counter=0.
//   Miss -> RESP with m_rdata=ERR_RDATA, bus_err=1, err_addr=m_addr, err_count+1.
//  ACCESS: slave i "done" when AUTOACK_MASK[i]=1 (first ACCESS cycle) or s_ready[i]=1.
//   Done -> capture s_rdata[i] into m_rdata, s_sel=0, s_wstrb=0, go RESP.
//   Not done -> counter+1; counter==TIMEOUT_CYCLES-1 with no ready -> forced completion:
//   m_rdata=ERR_RDATA, bus_err, err_addr, err_count as for miss. Ready in the same cycle wins.
//  RESP: m_ready=1 for exactly one cycle; next state IDLE; m_valid ignored in RESP.
//  Latency: autoack slave m_ready 2 cycles after m_valid; slave ready in cycle k -> m_ready k+1.
//  AUTOACK slaves see s_sel/s_wstrb for exactly one cycle (single write pulse).
//  s_ready of non-selected slaves ignored. m_valid drop during ACCESS: transaction still completes.
//  Writes return m_rdata per the same rules (CPU ignores it). err_count holds at 8'hff.
// STRUCTURE
//  Package soc_bus_pkg: state enum bus_state_t {IDLE,ACCESS,RESP}; ERR_RDATA default; byte lane widths.
//  Sub-module soc_bus_decode: combinational priority decode (addr byte -> hit, index); FSM,
//   timeout counter and error registers stay in soc_bus_fabric.
// TESTING
//  Read slave 1 (autoack=0), s_ready after 3 cycles, s_rdata[1]=32'h1234_5678 -> m_ready once, rdata 12345678.
//  Write 0x41 to 0xff00_0000 (slave 3, autoack) -> s_sel=4'b1000 & s_wstrb=0001 for 1 cycle, m_ready 2 cycles after m_valid.
//  Read 0x8000_0000 (unmapped) -> m_rdata=DEADBEEF, bus_err pulse, err_addr=8000_0000, err_count=1.
//  Slave 0 never readies, TIMEOUT_CYCLES=4 -> forced completion after 4 ACCESS cycles, DEADBEEF, bus_err.
//  300 misses -> err_count saturates at 255; duplicate bases -> lowest index selected.
//  n_reset low during ACCESS -> all outputs 0 immediately; next request decodes normally.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the picorv32 native-bus fabric.
// Imported by the interface, decoder and fabric top.
package soc_bus_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = WORD_W / BYTE_W;

  localparam logic [WORD_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bus_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soc_bus_if.sv
// CPU-side native bus plus one-hot slave-side bus seen by the fabric.
// master = surrounding system (CPU + peripherals), slave = the fabric itself.
interface soc_bus_if
  import soc_bus_pkg::*;
#(
  parameter int unsigned N_SLAVES = 6
) ();

  logic                       m_valid;
  logic                       m_instr;
  logic [WORD_W-1:0]          m_addr;
  logic [WORD_W-1:0]          m_wdata;
  logic [STRB_W-1:0]          m_wstrb;
  logic                       m_ready;
  logic [WORD_W-1:0]          m_rdata;

  logic [N_SLAVES-1:0]        s_sel;
  logic                       s_instr;
  logic [WORD_W-1:0]          s_addr;
  logic [WORD_W-1:0]          s_wdata;
  logic [STRB_W-1:0]          s_wstrb;
  logic [N_SLAVES-1:0]        s_ready;
  logic [N_SLAVES*WORD_W-1:0] s_rdata;

  modport master (
    output m_valid, m_instr, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    input  m_ready, m_rdata, s_sel, s_instr, s_addr, s_wdata, s_wstrb
  );

  modport slave (
    input  m_valid, m_instr, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    output m_ready, m_rdata, s_sel, s_instr, s_addr, s_wdata, s_wstrb
  );

endinterface

// File: rtl/soc_bus_decode.sv
// Combinational priority decode of the address top byte into a slave index.
// The lowest matching index wins when base entries are duplicated.
module soc_bus_decode
  import soc_bus_pkg::*;
#(
  parameter int unsigned                N_SLAVES    = 6,
  parameter logic [N_SLAVES*BYTE_W-1:0] SLAVE_BASES = '0,
  localparam int unsigned               IDX_W       = idx_width(N_SLAVES)
) (
  input  logic [BYTE_W-1:0] addr_byte,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  // Scan downwards so the lowest matching index is the last assignment.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
      if (SLAVE_BASES[i*BYTE_W +: BYTE_W] == addr_byte) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/soc_bus_fabric.sv
// picorv32 native-bus interconnect: top-byte decode, one-hot slave select,
// auto-ack, timeout and error reporting. All outputs come straight from flops.
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int unsigned                N_SLAVES       = 6,
  // Entry i occupies bits 8i+7:8i, so slave 0 is the rightmost byte.
  parameter logic [N_SLAVES*BYTE_W-1:0] SLAVE_BASES    = {8'hf1, 8'hf0, 8'hff, 8'hfe, 8'h01, 8'h00},
  parameter logic [N_SLAVES-1:0]        AUTOACK_MASK   = 6'b111100,
  parameter int unsigned                TIMEOUT_CYCLES = 255,
  parameter logic [WORD_W-1:0]          ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic              clk_cpu,
  input  logic              n_reset,
  soc_bus_if.slave          bus,
  output logic              bus_err,
  output logic [WORD_W-1:0] err_addr,
  output logic [7:0]        err_count
);

  localparam int unsigned     IDX_W    = idx_width(N_SLAVES);
  localparam int unsigned     TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_EN ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

  bus_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              instr_q, instr_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] err_addr_q, err_addr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx;
  logic              slave_done;
  logic              tmo_expired;
  logic              raise_err;
  logic [WORD_W-1:0] sel_rdata;

  soc_bus_decode #(
    .N_SLAVES    (N_SLAVES),
    .SLAVE_BASES (SLAVE_BASES)
  ) u_decode (
    .addr_byte (bus.m_addr[WORD_W-1 -: BYTE_W]),
    .hit       (dec_hit),
    .idx       (dec_idx)
  );

  // Auto-acked slaves finish on their first ACCESS cycle, so no first-cycle flag is needed.
  assign slave_done  = AUTOACK_MASK[idx_q] | bus.s_ready[idx_q];
  assign tmo_expired = TMO_EN && (tmo_q == TMO_LAST);
  assign sel_rdata   = bus.s_rdata[32'(idx_q) * WORD_W +: WORD_W];

  // State register
  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.m_valid) state_d = dec_hit ? ACCESS : RESP;
      ACCESS:  if (slave_done || tmo_expired) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.m_ready = (state_q == RESP);
    bus.m_rdata = rdata_q;
    bus.s_sel   = (state_q == ACCESS) ? (N_SLAVES'(1) << idx_q) : '0;
    bus.s_wstrb = (state_q == ACCESS) ? wstrb_q : '0;
    bus.s_instr = instr_q;
    bus.s_addr  = addr_q;
    bus.s_wdata = wdata_q;
    bus_err     = err_q;
    err_addr    = err_addr_q;
    err_count   = err_cnt_q;
  end

  // Datapath next state: request latch, read data capture, timeout and error tracking
  always_comb begin
    idx_d      = idx_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    tmo_d      = tmo_q;
    err_d      = 1'b0;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    raise_err  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.m_valid) begin
          idx_d   = dec_idx;
          instr_d = bus.m_instr;
          addr_d  = bus.m_addr;
          wdata_d = bus.m_wdata;
          wstrb_d = bus.m_wstrb;
          tmo_d   = '0;
          if (!dec_hit) begin
            rdata_d   = ERR_RDATA;
            raise_err = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (slave_done) begin
          rdata_d = sel_rdata;
        end else if (tmo_expired) begin
          rdata_d   = ERR_RDATA;
          raise_err = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (raise_err) begin
      err_d      = 1'b1;
      err_addr_d = (state_q == IDLE) ? bus.m_addr : addr_q;
      err_cnt_d  = (err_cnt_q == 8'hff) ? err_cnt_q : err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      idx_q      <= '0;
      instr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      idx_q      <= idx_d;
      instr_q    <= instr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Self-checking bench for soc_bus_fabric: directed scenarios plus randomized
// transactions against a transaction-level reference model.
module tb_soc_bus_fabric;
  import soc_bus_pkg::*;

  localparam int          N       = 6;
  localparam logic [47:0] BASES0  = {8'hf1, 8'hf0, 8'hff, 8'hfe, 8'h01, 8'h00};
  // Entry 4 duplicates entry 2 (0xfe); entry 2 must win.
  localparam logic [47:0] BASES1  = {8'hf1, 8'hfe, 8'hff, 8'hfe, 8'h01, 8'h00};
  localparam logic [5:0]  AUTOACK = 6'b111100;
  localparam int          TMO0    = 255;
  localparam int          TMO1    = 4;
  localparam logic [31:0] ERRW    = 32'hDEAD_BEEF;

  logic clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  logic            n_reset;
  logic            use2;
  logic            m_valid, m_instr;
  logic [31:0]     m_addr, m_wdata;
  logic [3:0]      m_wstrb;
  logic [N-1:0]    s_ready;
  logic [N*32-1:0] s_rdata;

  logic            bus_err0, bus_err1;
  logic [31:0]     err_addr0, err_addr1;
  logic [7:0]      err_count0, err_count1;

  soc_bus_if #(.N_SLAVES(N)) bus0 ();
  soc_bus_if #(.N_SLAVES(N)) bus1 ();

  assign bus0.m_valid = m_valid & ~use2;
  assign bus1.m_valid = m_valid & use2;
  assign bus0.m_instr = m_instr;
  assign bus1.m_instr = m_instr;
  assign bus0.m_addr  = m_addr;
  assign bus1.m_addr  = m_addr;
  assign bus0.m_wdata = m_wdata;
  assign bus1.m_wdata = m_wdata;
  assign bus0.m_wstrb = m_wstrb;
  assign bus1.m_wstrb = m_wstrb;
  assign bus0.s_ready = s_ready;
  assign bus1.s_ready = s_ready;
  assign bus0.s_rdata = s_rdata;
  assign bus1.s_rdata = s_rdata;

  soc_bus_fabric #(
    .N_SLAVES(N), .SLAVE_BASES(BASES0), .AUTOACK_MASK(AUTOACK),
    .TIMEOUT_CYCLES(TMO0), .ERR_RDATA(ERRW)
  ) dut0 (
    .clk_cpu(clk_cpu), .n_reset(n_reset), .bus(bus0),
    .bus_err(bus_err0), .err_addr(err_addr0), .err_count(err_count0)
  );

  soc_bus_fabric #(
    .N_SLAVES(N), .SLAVE_BASES(BASES1), .AUTOACK_MASK(AUTOACK),
    .TIMEOUT_CYCLES(TMO1), .ERR_RDATA(ERRW)
  ) dut1 (
    .clk_cpu(clk_cpu), .n_reset(n_reset), .bus(bus1),
    .bus_err(bus_err1), .err_addr(err_addr1), .err_count(err_count1)
  );

  // Observed outputs of whichever fabric is currently selected
  logic            m_ready, s_instr, bus_err;
  logic [31:0]     m_rdata, s_addr, s_wdata, err_addr;
  logic [N-1:0]    s_sel;
  logic [3:0]      s_wstrb;
  logic [7:0]      err_count;
  logic [148:0]    all_out;

  assign m_ready   = use2 ? bus1.m_ready : bus0.m_ready;
  assign m_rdata   = use2 ? bus1.m_rdata : bus0.m_rdata;
  assign s_sel     = use2 ? bus1.s_sel   : bus0.s_sel;
  assign s_instr   = use2 ? bus1.s_instr : bus0.s_instr;
  assign s_addr    = use2 ? bus1.s_addr  : bus0.s_addr;
  assign s_wdata   = use2 ? bus1.s_wdata : bus0.s_wdata;
  assign s_wstrb   = use2 ? bus1.s_wstrb : bus0.s_wstrb;
  assign bus_err   = use2 ? bus_err1     : bus_err0;
  assign err_addr  = use2 ? err_addr1    : err_addr0;
  assign err_count = use2 ? err_count1   : err_count0;
  assign all_out   = {m_ready, m_rdata, s_sel, s_instr, s_addr, s_wdata, s_wstrb,
                      bus_err, err_addr, err_count};

  int n_cmp  = 0;
  int n_fail = 0;

  int          err_cnt_m [2];
  logic [31:0] err_addr_m[2];

  typedef struct {
    int           lat;
    logic [31:0]  rdata;
    int           n_ready;
    int           n_err;
    int           sel_cycles;
    logic [N-1:0] sel_seen;
    logic [3:0]   wstrb_seen;
    logic [31:0]  addr_seen;
    logic [31:0]  wdata_seen;
    logic         instr_seen;
    int           gate_viol;
  } obs_t;

  // Transaction-level reference: which slave, how many select cycles, what comes back.
  function automatic void model(input int d, input logic [31:0] addr, input int rdy,
                                input logic [N*32-1:0] rd, output bit hit, output int idx,
                                output int lat, output int acc, output logic [31:0] rdata,
                                output bit err);
    logic [47:0] b;
    int          t;
    bit          in_time;
    b   = (d != 0) ? BASES1 : BASES0;
    t   = (d != 0) ? TMO1 : TMO0;
    hit = 1'b0;
    idx = -1;
    for (int i = 0; i < N; i++) begin
      if (!hit && b[i*8 +: 8] == addr[31:24]) begin
        hit = 1'b1;
        idx = i;
      end
    end
    if (!hit) begin
      lat = 1; acc = 0; rdata = ERRW; err = 1'b1;
      return;
    end
    in_time = (rdy >= 0) && (t == 0 || rdy + 1 <= t);
    if (AUTOACK[idx])  acc = 1;
    else if (in_time)  acc = rdy + 1;
    else               acc = t;
    err   = !AUTOACK[idx] && !in_time;
    rdata = err ? ERRW : rd[idx*32 +: 32];
    lat   = acc + 1;
  endfunction

  function automatic void note_err(input int d, input bit err, input logic [31:0] addr);
    if (err) begin
      err_cnt_m[d]  = (err_cnt_m[d] >= 255) ? 255 : err_cnt_m[d] + 1;
      err_addr_m[d] = addr;
    end
  endfunction

  // Acts as CPU and as the selected slave; s_ready rises once the slave has seen rdy select cycles.
  task automatic drive(input int d, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, input logic instr, input int rdy,
                       input bit drop, input bit noise, output obs_t o);
    int acc;
    o.lat = 0; o.rdata = '0; o.n_ready = 0; o.n_err = 0; o.sel_cycles = 0;
    o.sel_seen = '0; o.wstrb_seen = '0; o.addr_seen = '0; o.wdata_seen = '0;
    o.instr_seen = 1'b0; o.gate_viol = 0;
    acc = 0;
    @(negedge clk_cpu);
    use2 = (d != 0); m_valid = 1'b1; m_addr = addr; m_wstrb = strb; m_wdata = wdata;
    m_instr = instr; s_ready = '0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk_cpu);
      if (drop && c == 1) m_valid = 1'b0;
      if (s_sel != '0) begin
        acc++;
        o.sel_cycles++;
        o.sel_seen   |= s_sel;
        o.wstrb_seen |= s_wstrb;
        o.addr_seen  = s_addr;
        o.wdata_seen = s_wdata;
        o.instr_seen = s_instr;
      end else if (s_wstrb != '0) begin
        o.gate_viol++;
      end
      if (m_ready) begin
        o.n_ready++;
        if (o.lat == 0) begin
          o.lat   = c;
          o.rdata = m_rdata;
        end
        m_valid = 1'b0;
      end
      if (bus_err) o.n_err++;
      s_ready = (s_sel != '0 && rdy >= 0 && acc > rdy) ? s_sel : '0;
      if (noise) s_ready = s_ready | (N'($urandom) & ~s_sel);
      if (o.lat != 0 && c >= o.lat + 2) break;
    end
    m_valid = 1'b0;
    s_ready = '0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0; use2 = 1'b0; m_valid = 1'b0; m_instr = 1'b0; m_addr = '0;
    m_wdata = '0; m_wstrb = '0; s_ready = '0; s_rdata = '0;
    err_cnt_m = '{0, 0}; err_addr_m = '{32'h0, 32'h0};
    repeat (3) @(negedge clk_cpu);
    for (int d = 0; d < 2; d++) begin
      use2 = (d != 0); #1;
      n_cmp++;
      if (all_out !== '0) begin
        n_fail++; $display("FAIL reset_held[%0d] got %h want 0", d, all_out);
      end
    end
    n_reset = 1'b1;
    @(negedge clk_cpu); @(negedge clk_cpu);
    for (int d = 0; d < 2; d++) begin
      use2 = (d != 0); #1;
      n_cmp++;
      if (all_out !== '0) begin
        n_fail++; $display("FAIL reset_released[%0d] got %h want 0", d, all_out);
      end
    end
  endtask

  task automatic test_read_wait();
    obs_t o;
    s_rdata = '0;
    s_rdata[1*32 +: 32] = 32'h1234_5678;
    drive(0, 32'h0100_0010, 4'h0, 32'h0, 1'b1, 3, 1'b0, 1'b0, o);
    n_cmp++; if (o.lat !== 5) begin n_fail++; $display("FAIL rd_wait_lat got %0d want 5", o.lat); end
    n_cmp++; if (o.rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL rd_wait_data got %h want 12345678", o.rdata); end
    n_cmp++; if (o.n_ready !== 1) begin n_fail++; $display("FAIL rd_wait_pulses got %0d want 1", o.n_ready); end
    n_cmp++; if (o.sel_seen !== 6'b000010 || o.sel_cycles !== 4) begin
      n_fail++; $display("FAIL rd_wait_sel got %b/%0d want 000010/4", o.sel_seen, o.sel_cycles); end
    n_cmp++; if (o.instr_seen !== 1'b1 || o.n_err !== 0) begin
      n_fail++; $display("FAIL rd_wait_instr_err got %b/%0d want 1/0", o.instr_seen, o.n_err); end
  endtask

  task automatic test_autoack_write();
    obs_t o;
    drive(0, 32'hff00_0000, 4'b0001, 32'h41, 1'b0, -1, 1'b0, 1'b0, o);
    n_cmp++; if (o.sel_seen !== 6'b001000 || o.sel_cycles !== 1) begin
      n_fail++; $display("FAIL aa_sel got %b/%0d want 001000/1", o.sel_seen, o.sel_cycles); end
    n_cmp++; if (o.wstrb_seen !== 4'b0001 || o.wdata_seen !== 32'h41) begin
      n_fail++; $display("FAIL aa_wr got %b/%h want 0001/41", o.wstrb_seen, o.wdata_seen); end
    n_cmp++; if (o.lat !== 2) begin n_fail++; $display("FAIL aa_lat got %0d want 2", o.lat); end
    n_cmp++; if (o.gate_viol !== 0) begin n_fail++; $display("FAIL aa_gate got %0d want 0", o.gate_viol); end
  endtask

  task automatic test_miss();
    obs_t o;
    drive(0, 32'h8000_0000, 4'h0, 32'h0, 1'b0, 0, 1'b0, 1'b0, o);
    note_err(0, 1'b1, 32'h8000_0000);
    n_cmp++; if (o.lat !== 1 || o.rdata !== ERRW) begin
      n_fail++; $display("FAIL miss_resp got %0d/%h want 1/deadbeef", o.lat, o.rdata); end
    n_cmp++; if (o.n_err !== 1 || o.sel_seen !== '0) begin
      n_fail++; $display("FAIL miss_err got %0d/%b want 1/0", o.n_err, o.sel_seen); end
    n_cmp++; if (err_addr !== 32'h8000_0000 || err_count !== 8'd1) begin
      n_fail++; $display("FAIL miss_regs got %h/%0d want 80000000/1", err_addr, err_count); end
  endtask

  task automatic test_timeout();
    obs_t o;
    s_rdata = {6{32'h0F0F_1111}};
    drive(1, 32'h0000_0a00, 4'h0, 32'h0, 1'b0, -1, 1'b0, 1'b0, o);
    note_err(1, 1'b1, 32'h0000_0a00);
    n_cmp++; if (o.lat !== 5 || o.sel_cycles !== 4 || o.rdata !== ERRW) begin
      n_fail++; $display("FAIL tmo4 got %0d/%0d/%h want 5/4/deadbeef", o.lat, o.sel_cycles, o.rdata); end
    n_cmp++; if (o.n_err !== 1 || err_count !== 8'(err_cnt_m[1]) || err_addr !== 32'h0000_0a00) begin
      n_fail++; $display("FAIL tmo4_err got %0d/%0d/%h want 1/%0d/00000a00", o.n_err, err_count,
                         err_addr, err_cnt_m[1]); end
    // Ready in the final allowed cycle beats the timeout
    drive(1, 32'h0000_0b00, 4'h0, 32'h0, 1'b0, 3, 1'b0, 1'b0, o);
    n_cmp++; if (o.lat !== 5 || o.rdata !== 32'h0F0F_1111 || o.n_err !== 0) begin
      n_fail++; $display("FAIL tmo4_edge got %0d/%h/%0d want 5/0f0f1111/0", o.lat, o.rdata, o.n_err); end
    drive(0, 32'h0000_0c00, 4'h0, 32'h0, 1'b0, -1, 1'b0, 1'b0, o);
    note_err(0, 1'b1, 32'h0000_0c00);
    n_cmp++; if (o.lat !== 256 || o.rdata !== ERRW || err_count !== 8'(err_cnt_m[0])) begin
      n_fail++; $display("FAIL tmo255 got %0d/%h/%0d want 256/deadbeef/%0d", o.lat, o.rdata,
                         err_count, err_cnt_m[0]); end
  endtask

  task automatic test_duplicate();
    obs_t o;
    s_rdata = {32'h5555_5555, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0};
    drive(1, 32'hfe12_3456, 4'hf, 32'hcafe, 1'b0, -1, 1'b0, 1'b0, o);
    n_cmp++; if (o.sel_seen !== 6'b000100 || o.rdata !== 32'h2222_2222) begin
      n_fail++; $display("FAIL dup_sel got %b/%h want 000100/22222222", o.sel_seen, o.rdata); end
  endtask

  task automatic test_random();
    obs_t o; bit hit, err; int idx, lat, acc, d, rdy; logic [31:0] addr, rd; logic [3:0] strb;
    logic [47:0] b;
    for (int k = 0; k < 40; k++) begin
      d = int'($urandom_range(0, 1));
      b = (d != 0) ? BASES1 : BASES0;
      addr = $urandom;
      if ($urandom_range(0, 9) < 7) addr[31:24] = b[$urandom_range(0, N - 1) * 8 +: 8];
      rdy  = int'($urandom_range(0, 7)) - 1;
      strb = 4'($urandom);
      for (int i = 0; i < N; i++) s_rdata[i*32 +: 32] = $urandom;
      model(d, addr, rdy, s_rdata, hit, idx, lat, acc, rd, err);
      drive(d, addr, strb, $urandom, 1'($urandom), rdy, 1'($urandom), 1'b1, o);
      note_err(d, err, addr);
      n_cmp++; if (o.lat !== lat || o.rdata !== rd) begin
        n_fail++; $display("FAIL rand_resp[%0d] got %0d/%h want %0d/%h", k, o.lat, o.rdata, lat, rd); end
      n_cmp++; if (o.n_ready !== 1 || o.n_err !== int'(err)) begin
        n_fail++; $display("FAIL rand_pulse[%0d] got %0d/%0d want 1/%0d", k, o.n_ready, o.n_err, err); end
      n_cmp++; if (o.sel_seen !== (hit ? N'(1) << idx : N'(0)) || o.sel_cycles !== acc) begin
        n_fail++; $display("FAIL rand_sel[%0d] got %b/%0d want idx %0d/%0d", k, o.sel_seen,
                           o.sel_cycles, idx, acc); end
      n_cmp++; if (o.wstrb_seen !== (hit ? strb : 4'h0) || o.gate_viol !== 0 ||
                   (hit && o.addr_seen !== addr)) begin
        n_fail++; $display("FAIL rand_wr[%0d] got %b/%0d/%h want %b/0/%h", k, o.wstrb_seen,
                           o.gate_viol, o.addr_seen, strb, addr); end
      n_cmp++; if (err_count !== 8'(err_cnt_m[d]) || err_addr !== err_addr_m[d]) begin
        n_fail++; $display("FAIL rand_errregs[%0d] got %0d/%h want %0d/%h", k, err_count, err_addr,
                           err_cnt_m[d], err_addr_m[d]); end
    end
  endtask

  task automatic test_saturate();
    obs_t o; logic [31:0] addr;
    for (int i = 0; i < 300; i++) begin
      addr = {4'h8, 4'(i), 24'($urandom)};
      drive(0, addr, 4'h0, 32'h0, 1'b0, 0, 1'b0, 1'b0, o);
      note_err(0, 1'b1, addr);
      if (i % 60 == 0 || i == 299) begin
        n_cmp++;
        if (err_count !== 8'(err_cnt_m[0]) || err_addr !== addr) begin
          n_fail++; $display("FAIL sat[%0d] got %0d/%h want %0d/%h", i, err_count, err_addr,
                             err_cnt_m[0], addr); end
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o; logic [31:0] d3;
    @(negedge clk_cpu);
    use2 = 1'b0; m_valid = 1'b1; m_addr = 32'h0000_0040; m_wstrb = 4'h3; s_ready = '0;
    @(negedge clk_cpu);
    n_cmp++; if (s_sel !== 6'b000001) begin
      n_fail++; $display("FAIL mid_sel got %b want 000001", s_sel); end
    #2 n_reset = 1'b0;
    #1;
    n_cmp++; if (all_out !== '0) begin
      n_fail++; $display("FAIL mid_reset got %h want 0", all_out); end
    m_valid = 1'b0;
    @(negedge clk_cpu); @(negedge clk_cpu);
    n_reset = 1'b1;
    err_cnt_m = '{0, 0}; err_addr_m = '{32'h0, 32'h0};
    for (int i = 0; i < N; i++) s_rdata[i*32 +: 32] = $urandom;
    d3 = s_rdata[3*32 +: 32];
    drive(0, 32'hff00_0100, 4'h0, 32'h0, 1'b0, -1, 1'b0, 1'b0, o);
    n_cmp++; if (o.lat !== 2 || o.rdata !== d3 || o.sel_seen !== 6'b001000 || o.n_ready !== 1) begin
      n_fail++; $display("FAIL post_reset got %0d/%h/%b/%0d want 2/%h/001000/1", o.lat, o.rdata,
                         o.sel_seen, o.n_ready, d3); end
    n_cmp++; if (err_count !== 8'd0) begin
      n_fail++; $display("FAIL post_reset_cnt got %0d want 0", err_count); end
  endtask

  initial begin
    test_reset();
    test_read_wait();
    test_autoack_write();
    test_miss();
    test_timeout();
    test_duplicate();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
